// File: rtl/tx_spi_fifo.sv
// SPI-fed transmit byte FIFO with IDLE/LOAD/DRAIN frame control.
// Define TX_SPI_FIFO_JABBER_EN to add the per-frame cycle watchdog.
module tx_spi_fifo #(
  parameter int unsigned DEPTH        = 8,
  parameter logic [19:0] JABBER_LIMIT = 20'hFFFFF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [15:0]            spi_data,
  input  logic                   spi_data_strobe,
  output logic                   spi_data_request,
  input  logic                   go,
  input  logic                   abort,
  output logic [7:0]             tx_byte,
  output logic                   tx_valid,
  output logic                   tx_last,
  input  logic                   byte_consumed,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overrun,
  output logic                   underrun,
  output logic                   jabber,
  output logic                   busy
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FULL   = LW'(DEPTH);
  localparam logic [LW-1:0] ALMOST = LW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } state_e;

  state_e        state_q;
  logic          stb_q;
  logic          go_q;
  logic          arm_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          pend_q;
  logic [DEPTH-1:0] last_q;
  logic [7:0]    mem_q [DEPTH];
  logic          req_q;
  logic [7:0]    tx_byte_q;
  logic          tx_valid_q;
  logic          tx_last_q;
  logic          ovr_q;
  logic          und_q;

  logic          stb_edge;
  logic          go_edge;
  logic          in_load;
  logic          flush;
  logic          jab_hit;
  logic          empty;
  logic          full;
  logic          push_req;
  logic          mark;
  logic          pop;
  logic          push;
  logic          set_ovr;
  logic          set_und;
  logic          start;
  logic          last_in;
  logic [LW-1:0] lvl_ap;
  logic [LW-1:0] level_d;
  logic [PW-1:0] wr_ptr_d;
  logic [PW-1:0] rd_ptr_d;
  logic [PW-1:0] tail_ptr;
  logic          mark_tail;
  logic          mark_pend;
  logic          eop_acc;
  logic [7:0]    head_byte_d;
  logic          head_last_d;
  logic          unused_bits;

  assign unused_bits = ^spi_data[13:8];

  // go is only honoured once a clean low has been seen after reset
  assign stb_edge = spi_data_strobe & ~stb_q;
  assign go_edge  = go & ~go_q & arm_q;
  assign in_load  = (state_q == LOAD);
  assign flush    = abort | jab_hit;
  assign empty    = (level_q == '0);
  assign full     = (level_q == FULL);

  assign push_req = in_load & stb_edge & spi_data[14] & ~flush;
  assign mark     = in_load & stb_edge & ~spi_data[14]
                  & spi_data[15] & ~flush;
  assign pop      = byte_consumed & ~empty & ~flush;
  assign push     = push_req & (~full | pop);
  assign set_ovr  = push_req & full & ~pop;
  assign set_und  = byte_consumed & empty & ~flush;
  assign start    = (state_q == IDLE) & go_edge & ~flush;
  assign last_in  = spi_data[15] | pend_q;

  assign lvl_ap   = level_q - LW'(pop);
  assign level_d  = lvl_ap + LW'(push);
  assign wr_ptr_d = wr_ptr_q + PW'(push);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);
  assign tail_ptr = wr_ptr_q - PW'(1);

  // a marker with nothing left to tag is held for the next pushed byte
  assign mark_tail = mark & (lvl_ap != '0);
  assign mark_pend = mark & (lvl_ap == '0);
  assign eop_acc   = (push & last_in) | mark_tail;

  assign head_byte_d = (lvl_ap == '0) ? spi_data[7:0]
                                      : mem_q[rd_ptr_d];
  assign head_last_d = (lvl_ap == '0) ? last_in
                     : (last_q[rd_ptr_d]
                        | (mark_tail & (rd_ptr_d == tail_ptr)));

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= spi_data[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      stb_q      <= 1'b0;
      go_q       <= 1'b0;
      arm_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pend_q     <= 1'b0;
      last_q     <= '0;
      req_q      <= 1'b0;
      tx_byte_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      ovr_q      <= 1'b0;
      und_q      <= 1'b0;
    end else begin
      stb_q <= spi_data_strobe;
      go_q  <= go;
      arm_q <= 1'b1;
      if (flush) begin
        state_q    <= IDLE;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        level_q    <= '0;
        pend_q     <= 1'b0;
        req_q      <= 1'b0;
        tx_valid_q <= 1'b0;
        tx_last_q  <= 1'b0;
      end else begin
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        level_q    <= level_d;
        if (push) last_q[wr_ptr_q] <= last_in;
        if (mark_tail) last_q[tail_ptr] <= 1'b1;
        pend_q     <= push ? 1'b0 : (pend_q | mark_pend);
        tx_valid_q <= (level_d != '0);
        tx_last_q  <= (level_d != '0) & head_last_d;
        if (level_d != '0) tx_byte_q <= head_byte_d;
        if (start) begin
          ovr_q <= 1'b0;
          und_q <= 1'b0;
        end else begin
          ovr_q <= ovr_q | set_ovr;
          und_q <= und_q | set_und;
        end
        unique case (state_q)
          IDLE: begin
            req_q <= start & (level_d < ALMOST);
            if (start) state_q <= LOAD;
          end
          LOAD: begin
            if (eop_acc) begin
              state_q <= DRAIN;
              req_q   <= 1'b0;
            end else begin
              req_q <= (level_d < ALMOST);
            end
          end
          DRAIN: begin
            req_q <= 1'b0;
            if (pop & tx_last_q) state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef TX_SPI_FIFO_JABBER_EN
  logic [19:0] jab_cnt_q;
  logic        jab_q;

  assign jab_hit = (state_q != IDLE)
                 & (({1'b0, jab_cnt_q} + 21'd1)
                    >= {1'b0, JABBER_LIMIT});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jab_cnt_q <= '0;
      jab_q     <= 1'b0;
    end else if (start) begin
      jab_cnt_q <= '0;
      jab_q     <= 1'b0;
    end else begin
      if (state_q != IDLE) jab_cnt_q <= jab_cnt_q + 20'd1;
      if (jab_hit) jab_q <= 1'b1;
    end
  end

  assign jabber = jab_q;
`else
  logic unused_jab_limit;

  assign unused_jab_limit = ^JABBER_LIMIT;
  assign jab_hit          = 1'b0;
  assign jabber           = 1'b0;
`endif

  assign spi_data_request = req_q;
  assign tx_byte          = tx_byte_q;
  assign tx_valid         = tx_valid_q;
  assign tx_last          = tx_last_q;
  assign level            = level_q;
  assign overrun          = ovr_q;
  assign underrun         = und_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: doc/tx_spi_fifo.md
TX_SPI_FIFO -- requirements
Module: tx_spi_fifo

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; power of two, 2..64.
REQ-002 Parameter JABBER_LIMIT, default 20'hFFFFF: maximum clk cycles per frame; 20-bit value.
REQ-003 Port clk, input, 1: sole clock; all logic is on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous active-low reset.
REQ-005 Port spi_data, input, 16: bit15 = end of packet (eop); bit14 = byte valid; bits 7:0 = byte.
REQ-006 Port spi_data_strobe, input, 1: a rising edge qualifies spi_data.
REQ-007 Port spi_data_request, output, 1: block wants more SPI words.
REQ-008 Port go, input, 1: a rising edge starts a frame.
REQ-009 Port abort, input, 1: level-sensitive; flushes and ends the frame.
REQ-010 Port tx_byte, output, 8: FIFO head byte.
REQ-011 Port tx_valid, output, 1: FIFO not empty.
REQ-012 Port tx_last, output, 1: head byte is the last byte of the packet.
REQ-013 Port byte_consumed, input, 1: single-cycle pulse from the framer that pops the head.
REQ-014 Port level, output, log2(DEPTH)+1: current occupancy.
REQ-015 Ports overrun, underrun, jabber, output, 1 each: sticky error flags.
REQ-016 Port busy, output, 1: state is not IDLE.

Function
REQ-017 The block SHALL edge-detect spi_data_strobe and go using one registered copy of each; the action occurs in the cycle after the edge is registered.
REQ-018 A strobe edge with bit14=1 SHALL push {bit15, bits 7:0}; a strobe edge with bit14=0 and bit15=1 SHALL mark the last stored entry (or the next pushed entry, if the FIFO is empty) as last.
REQ-019 A push when level==DEPTH SHALL drop the word and set overrun, unless byte_consumed is also high that cycle; in that case both the pop and the push complete and no overrun is set.
REQ-020 byte_consumed with tx_valid=0 SHALL set underrun and leave level unchanged.
REQ-021 tx_byte, tx_valid and tx_last SHALL be registered; a push into an empty FIFO becomes visible one cycle after the push.
REQ-022 The FIFO pointers SHALL wrap modulo DEPTH, and level SHALL be exact from 0 to DEPTH.
REQ-023 The state machine SHALL have three states: IDLE, LOAD and DRAIN.
REQ-024 IDLE -> LOAD on a go edge; this transition clears overrun, underrun and jabber and asserts spi_data_request.
REQ-025 LOAD -> DRAIN when an eop-marked word is accepted; spi_data_request SHALL drop in the same cycle.
REQ-026 In LOAD, spi_data_request SHALL be 0 while level >= DEPTH-1 and 1 otherwise.
REQ-027 DRAIN -> IDLE when the last-marked byte is consumed; spi_data_request is 0 in DRAIN and IDLE.
REQ-028 Strobe edges in IDLE or DRAIN SHALL be ignored and set no flags.
REQ-029 A go edge outside IDLE SHALL be ignored.
REQ-030 abort=1 in any state SHALL flush the FIFO (level=0), force IDLE and drop spi_data_request in the next cycle; abort takes priority over push, pop and go in the same cycle.

Reset
REQ-031 While reset_n=0, the block SHALL hold these values asynchronously:
- state IDLE
- pointers and level 0
- tx_byte 8'h00; tx_valid, tx_last, spi_data_request, overrun, underrun, jabber and busy all 0
- edge-detect registers 0
REQ-032 Assertion of reset_n mid-frame SHALL discard all FIFO contents, and no flag SHALL survive it.
REQ-033 After reset_n deasserts, a go level already high SHALL NOT count as an edge.

Configuration
REQ-034 With macro TX_SPI_FIFO_JABBER_EN defined:
- a 20-bit counter clears on IDLE -> LOAD and increments each cycle outside IDLE
- on reaching JABBER_LIMIT, the block sets jabber and performs the REQ-030 abort action
REQ-035 Without TX_SPI_FIFO_JABBER_EN, the counter SHALL be absent, jabber SHALL be tied to 0, and no forced abort SHALL occur.

Verification
REQ-036 go edge, then 3 strobes carrying 16'h40A1, 16'h40B2, 16'hC0C3 -> level reaches 3; state DRAIN; request drops after the third word; tx_last=1 only with tx_byte=8'hC3.
REQ-037 DEPTH=8, 9 pushes with no pops -> request low at level 7; the 9th word is dropped; overrun=1; level=8.
REQ-038 Full FIFO, push and byte_consumed in the same cycle -> level stays 8; overrun stays 0.
REQ-039 byte_consumed on an empty FIFO in LOAD -> underrun=1; level=0; the next go edge clears underrun.
REQ-040 abort asserted with level=5 -> next cycle level=0, tx_valid=0, busy=0, request=0.
REQ-041 TX_SPI_FIFO_JABBER_EN defined, JABBER_LIMIT=100, go with no eop -> jabber=1 and state IDLE at cycle 100 after LOAD entry.
